// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the ALU execute sequencer
package alu_pkg;

   localparam logic [31:0] ID_ADD   = 32'd1;
   localparam logic [31:0] ID_SUB   = 32'd2;
   localparam logic [31:0] ID_ADDU  = 32'd3;
   localparam logic [31:0] ID_SUBU  = 32'd4;
   localparam logic [31:0] ID_ADDI  = 32'd5;
   localparam logic [31:0] ID_ADDIU = 32'd6;
   localparam logic [31:0] ID_AND   = 32'd7;
   localparam logic [31:0] ID_OR    = 32'd8;
   localparam logic [31:0] ID_ANDI  = 32'd9;
   localparam logic [31:0] ID_ORI   = 32'd10;
   localparam logic [31:0] ID_SLL   = 32'd11;
   localparam logic [31:0] ID_SRL   = 32'd12;

   localparam int RS_LSB = 21;
   localparam int RT_LSB = 16;
   localparam int RD_LSB = 11;
   localparam int SH_LSB = 6;
   localparam int IMM_W  = 16;

   localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;
   typedef enum logic [1:0] {B_REG, B_SIMM, B_ZIMM, B_SHAMT} bsrc_e;
   typedef enum logic [1:0] {OVF_NONE, OVF_ADD, OVF_SUB} ovf_e;

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - combinational decode of the instruction ID into datapath controls
module alu_seq_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr_id_i,
   output logic        dest_rt_o,
   output bsrc_e       b_src_o,
   output logic        legal_o,
   output ovf_e        ovf_class_o,
   output logic        a_from_rt_o
);

   always_comb begin
      dest_rt_o   = 1'b0;
      b_src_o     = B_REG;
      legal_o     = 1'b1;
      ovf_class_o = OVF_NONE;
      a_from_rt_o = 1'b0;
      case (instr_id_i)
         ID_ADD:  ovf_class_o = OVF_ADD;
         ID_SUB:  ovf_class_o = OVF_SUB;
         ID_ADDU, ID_SUBU, ID_AND, ID_OR: ;
         ID_ADDI: begin
            dest_rt_o   = 1'b1;
            b_src_o     = B_SIMM;
            ovf_class_o = OVF_ADD;
         end
         ID_ADDIU: begin
            dest_rt_o = 1'b1;
            b_src_o   = B_SIMM;
         end
         ID_ANDI, ID_ORI: begin
            dest_rt_o = 1'b1;
            b_src_o   = B_ZIMM;
         end
         // shifts take their data operand from rt, amount from shamt
         ID_SLL, ID_SRL: begin
            b_src_o     = B_SHAMT;
            a_from_rt_o = 1'b1;
         end
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - four-state execute controller: read, execute, write-back, PC advance
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int          DATA_W   = 32,
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [31:0]       ir,
   input  logic [31:0]       instr_ID,
   output logic [4:0]        rf_raddr_a,
   output logic [4:0]        rf_raddr_b,
   input  logic [DATA_W-1:0] rf_rdata_a,
   input  logic [DATA_W-1:0] rf_rdata_b,
   output logic [3:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   output logic              rf_we,
   output logic [4:0]        rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [31:0]       pc,
   output logic              busy,
   output logic              done,
   output logic              illegal,
   output logic              overflow
);

   localparam int MSB = DATA_W - 1;

   state_e            state_q, state_d;
   logic [25:0]       ir_q, ir_d;
   logic [31:0]       id_q, id_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_q, res_d;
   logic [3:0]        alu_op_q, alu_op_d;
   logic [4:0]        waddr_q, waddr_d;
   logic              ovf_q, ovf_d, legal_q, legal_d;
   logic [31:0]       pc_q, pc_d;

   logic              dest_rt, legal, a_from_rt, in_exec, ovf_now;
   bsrc_e             b_src;
   ovf_e              ovf_class;
   logic [4:0]        rs, rt, rd, shamt;
   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] b_sel;
   logic              unused_ir_hi;

   assign unused_ir_hi = ^ir[31:26];

   alu_seq_decode u_decode (
      .instr_id_i  (id_q),
      .dest_rt_o   (dest_rt),
      .b_src_o     (b_src),
      .legal_o     (legal),
      .ovf_class_o (ovf_class),
      .a_from_rt_o (a_from_rt)
   );

   assign rs    = ir_q[RS_LSB +: 5];
   assign rt    = ir_q[RT_LSB +: 5];
   assign rd    = ir_q[RD_LSB +: 5];
   assign shamt = ir_q[SH_LSB +: 5];
   assign imm   = ir_q[IMM_W-1:0];

   assign rf_raddr_a = a_from_rt ? rt : rs;
   assign rf_raddr_b = rt;

   always_comb begin
      b_sel = rf_rdata_b;
      case (b_src)
         B_SIMM:  b_sel = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
         B_ZIMM:  b_sel = {{(DATA_W-IMM_W){1'b0}}, imm};
         B_SHAMT: b_sel = {{(DATA_W-5){1'b0}}, shamt};
         default: b_sel = rf_rdata_b;
      endcase
   end

   // Read data only arrives in EXEC, so operands pass through there and are held afterwards
   assign in_exec = (state_q == EXEC);
   assign alu_a   = in_exec ? rf_rdata_a : alu_a_q;
   assign alu_b   = in_exec ? b_sel : alu_b_q;
   assign alu_op  = in_exec ? id_q[3:0] : alu_op_q;

   always_comb begin
      ovf_now = 1'b0;
      case (ovf_class)
         OVF_ADD: ovf_now = (alu_a[MSB] == alu_b[MSB]) && (alu_result[MSB] != alu_a[MSB]);
         OVF_SUB: ovf_now = (alu_a[MSB] != alu_b[MSB]) && (alu_result[MSB] != alu_a[MSB]);
         default: ovf_now = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      id_d        = id_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      res_d       = res_q;
      waddr_d     = waddr_q;
      ovf_d       = ovf_q;
      legal_d     = legal_q;
      pc_d        = pc_q;
      instr_ready = 1'b0;
      rf_we       = 1'b0;
      done        = 1'b0;
      illegal     = 1'b0;
      overflow    = 1'b0;
      case (state_q)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               ir_d    = ir[25:0];
               id_d    = instr_ID;
               state_d = READ;
            end
         end
         READ: state_d = EXEC;
         EXEC: begin
            alu_a_d  = alu_a;
            alu_b_d  = alu_b;
            alu_op_d = alu_op;
            res_d    = alu_result;
            waddr_d  = dest_rt ? rt : rd;
            ovf_d    = ovf_now;
            legal_d  = legal;
            pc_d     = pc_q + PC_STEP;
            state_d  = WB;
         end
         WB: begin
            done     = 1'b1;
            illegal  = !legal_q;
            overflow = ovf_q;
            rf_we    = legal_q && !ovf_q && (waddr_q != 5'd0);
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         ir_q     <= '0;
         id_q     <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         res_q    <= '0;
         waddr_q  <= '0;
         ovf_q    <= 1'b0;
         legal_q  <= 1'b0;
         pc_q     <= PC_RESET;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         id_q     <= id_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_op_q <= alu_op_d;
         res_q    <= res_d;
         waddr_q  <= waddr_d;
         ovf_q    <= ovf_d;
         legal_q  <= legal_d;
         pc_q     <= pc_d;
      end
   end

   assign rf_waddr = waddr_q;
   assign rf_wdata = res_q;
   assign pc       = pc_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench with register-file and ALU models around alu_sequencer
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] ir, instr_ID;
   logic [4:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
   logic [31:0] rf_rdata_a, rf_rdata_b, alu_a, alu_b, alu_result, rf_wdata, pc;
   logic [3:0]  alu_op;
   logic        rf_we, busy, done, illegal, overflow;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .ir(ir), .instr_ID(instr_ID), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
      .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .alu_op(alu_op), .alu_a(alu_a),
      .alu_b(alu_b), .alu_result(alu_result), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .pc(pc), .busy(busy), .done(done), .illegal(illegal),
      .overflow(overflow)
   );

   logic [31:0] regs [32] = '{1: 32'd5, 3: 32'h0000_F000, 4: 32'd1, 5: 32'h7FFF_FFFF,
                              6: 32'd1, default: 32'd0};

   always @(posedge clk) begin
      if (rf_we && rf_waddr != 5'd0) regs[rf_waddr] <= rf_wdata;
      rf_rdata_a <= regs[rf_raddr_a];
      rf_rdata_b <= regs[rf_raddr_b];
   end

   always_comb begin
      alu_result = 32'd0;
      case (alu_op)
         4'd1, 4'd3, 4'd5, 4'd6: alu_result = alu_a + alu_b;
         4'd2, 4'd4:             alu_result = alu_a - alu_b;
         4'd7, 4'd9:             alu_result = alu_a & alu_b;
         4'd8, 4'd10:            alu_result = alu_a | alu_b;
         4'd11:                  alu_result = alu_a << alu_b[4:0];
         4'd12:                  alu_result = alu_a >> alu_b[4:0];
         default:                alu_result = 32'd0;
      endcase
   end

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        ill;
      logic        ovf;
   } exp_t;

   exp_t        sb [$];
   int          acc_q [$];
   int          n_cmp = 0, n_err = 0;
   int          cyc = 0, since_acc = 99, last_acc = 0, prev_acc = 0;
   logic [31:0] pc_exp = 32'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t ref_model(input logic [31:0] id, input logic [31:0] w);
      exp_t        e;
      logic [4:0]  rs, rt, rd, dst;
      logic [31:0] a, b, r, simm, zimm;
      longint      s;
      logic        ovf;
      rs = w[25:21]; rt = w[20:16]; rd = w[15:11];
      simm = {{16{w[15]}}, w[15:0]};
      zimm = {16'd0, w[15:0]};
      a = regs[rs]; b = regs[rt]; r = 32'd0; ovf = 1'b0; dst = rd; s = 0;
      case (id)
         1:  begin r = a + b; s = longint'($signed(a)) + longint'($signed(b)); end
         2:  begin r = a - b; s = longint'($signed(a)) - longint'($signed(b)); end
         3:  r = a + b;
         4:  r = a - b;
         5:  begin r = a + simm; s = longint'($signed(a)) + longint'($signed(simm)); dst = rt; end
         6:  begin r = a + simm; dst = rt; end
         7:  r = a & b;
         8:  r = a | b;
         9:  begin r = a & zimm; dst = rt; end
         10: begin r = a | zimm; dst = rt; end
         11: r = regs[rt] << w[10:6];
         12: r = regs[rt] >> w[10:6];
         default: ;
      endcase
      if (id == 1 || id == 2 || id == 5)
         ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      e.ill   = !(id >= 1 && id <= 12);
      e.ovf   = ovf;
      e.waddr = dst;
      e.wdata = r;
      e.we    = !e.ill && !ovf && dst != 5'd0;
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      int   a;
      if (reset && instr_valid && instr_ready) begin
         sb.push_back(ref_model(instr_ID, ir));
         acc_q.push_back(cyc);
         prev_acc  = last_acc;
         last_acc  = cyc;
         since_acc = 0;
      end else if (since_acc < 99) begin
         since_acc++;
         if (since_acc >= 1 && since_acc <= 3) chk("ready_low", {31'd0, instr_ready}, 32'd0);
      end
      if (done) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            a = acc_q.pop_front();
            chk("latency", cyc - a, 32'd3);
            chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
            chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
            chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
            if (e.we) begin
               chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.waddr});
               chk("rf_wdata", rf_wdata, e.wdata);
            end
            pc_exp = pc_exp + 32'd4;
            chk("pc", pc, pc_exp);
         end
      end
   end

   function automatic logic [31:0] r_ir(input int rs, input int rt, input int rd, input int sh);
      r_ir = {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], 6'd0};
   endfunction

   function automatic logic [31:0] i_ir(input int rs, input int rt, input logic [15:0] imm);
      i_ir = {6'd0, rs[4:0], rt[4:0], imm};
   endfunction

   task automatic issue(input logic [31:0] id, input logic [31:0] w, input bit keep);
      int t = 0;
      instr_valid = 1'b1;
      instr_ID    = id;
      ir          = w;
      while (!instr_ready && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 20) chk("issue_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      if (!keep) instr_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 20) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      reset = 1'b0; instr_valid = 1'b0; ir = 32'd0; instr_ID = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pc", pc, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, instr_ready}, 32'd1);
      chk("rst_we_done", {30'd0, rf_we, done}, 32'd0);
      chk("rst_flags", {30'd0, illegal, overflow}, 32'd0);
      chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      issue(5,  i_ir(1, 2, 16'hFFFF), 0); wait_idle();
      issue(1,  r_ir(5, 6, 7, 0), 0);     wait_idle();
      issue(3,  r_ir(5, 6, 7, 0), 0);     wait_idle();
      issue(13, r_ir(1, 1, 8, 0), 0);     wait_idle();
      issue(0,  r_ir(1, 1, 8, 0), 0);     wait_idle();
      issue(1,  r_ir(1, 1, 0, 0), 0);     wait_idle();
      issue(10, i_ir(3, 9, 16'h8001), 0); wait_idle();
      issue(11, r_ir(1, 4, 10, 31), 0);   wait_idle();
      issue(12, r_ir(1, 5, 11, 4), 0);    wait_idle();
      issue(2,  r_ir(10, 6, 12, 0), 0);   wait_idle();
      issue(4,  r_ir(1, 3, 12, 0), 0);    wait_idle();
      issue(9,  i_ir(5, 16, 16'hF0F0), 0); wait_idle();
      issue(6,  i_ir(3, 17, 16'h8000), 0); wait_idle();

      issue(7, r_ir(1, 3, 13, 0), 1);
      issue(8, r_ir(4, 6, 14, 0), 0);
      chk("b2b_spacing", last_acc - prev_acc, 32'd4);
      wait_idle();

      issue(5, i_ir(1, 15, 16'd7), 0);
      @(posedge clk); #1;
      reset     = 1'b0;
      sb.delete();
      acc_q.delete();
      pc_exp    = 32'd0;
      since_acc = 99;
      #1;
      chk("exec_rst_pc", pc, 32'd0);
      chk("exec_rst_busy", {31'd0, busy}, 32'd0);
      chk("exec_rst_we", {31'd0, rf_we}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("exec_rst_r15", regs[15], 32'd0);
      issue(5, i_ir(1, 15, 16'd7), 0); wait_idle();
      @(posedge clk); #1;
      chk("post_rst_r15", regs[15], 32'd12);

      for (int i = 0; i < 24; i++) begin
         issue($urandom_range(0, 14),
               {6'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 16'($urandom)}, 0);
         wait_idle();
      end

      repeat (2) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle execute controller that sits between instruction fetch and the ALU/register file.
- Accepts one instruction (ir + instr_ID) per valid/ready handshake.
- Sequences register read, ALU operand/opcode drive, overflow check, write-back and PC advance.
- Owns the PC and is the only writer of the register file on this path.

Parameters:
DATA_W, 32, datapath and register width
PC_RESET, 32'h0000_0000, PC value after reset
PC_STEP, 4, PC increment per retired instruction

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
instr_valid  in  1  fetch presents an instruction
instr_ready  out  1  sequencer can accept an instruction
ir  in  32  instruction word: rs=ir[25:21], rt=ir[20:16], rd=ir[15:11], shamt=ir[10:6], imm=ir[15:0]
instr_ID  in  32  operation code, 1..12 = add,sub,addu,subu,addi,addiu,and,or,andi,ori,sll,srl
rf_raddr_a  out  5  register file read address A
rf_raddr_b  out  5  register file read address B
rf_rdata_a  in  DATA_W  read data A, valid one cycle after address
rf_rdata_b  in  DATA_W  read data B, valid one cycle after address
alu_op  out  4  instr_ID[3:0] of the captured instruction
alu_a  out  DATA_W  ALU operand A
alu_b  out  DATA_W  ALU operand B
alu_result  in  DATA_W  combinational ALU result
rf_we  out  1  write-back strobe
rf_waddr  out  5  write-back address
rf_wdata  out  DATA_W  write-back data
pc  out  32  program counter
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when an instruction retires
illegal  out  1  one-cycle pulse with done, set for instr_ID 0 or >12
overflow  out  1  one-cycle pulse with done, set on signed overflow of add/sub/addi

Behaviour:
- Reset (reset==0, async):
  - state=IDLE, pc=PC_RESET.
  - rf_we, done, illegal, overflow = 0; alu_op=0, alu_a=0, alu_b=0, rf_waddr=0, rf_wdata=0.
  - Any captured instruction is discarded with no write.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, register ir/instr_ID and go to READ.
  - Otherwise stay in IDLE.
- READ:
  - Drive rf_raddr_a=rs, rf_raddr_b=rt.
  - For sll/srl, rf_raddr_a=rt.
  - Go to EXEC.
- EXEC: drive alu_op and registered operands.
  - R-type (add,sub,addu,subu,and,or): a=rdata_a, b=rdata_b, dest=rd.
  - addi/addiu: a=rdata_a, b=sign-extended imm, dest=rt.
  - andi/ori: a=rdata_a, b=zero-extended imm, dest=rt.
  - sll/srl: a=rdata_a (rt value), b=zero-extended shamt, dest=rd.
  - Capture alu_result and the overflow flag, then go to WB.
- Overflow rules:
  - add/addi: a[31]==b[31] && res[31]!=a[31].
  - sub: a[31]!=b[31] && res[31]!=a[31].
  - addu/subu/addiu never overflow.
- WB:
  - rf_we=1 for exactly this cycle only if legal && !overflow && dest!=0.
  - pc += PC_STEP for every instruction, including illegal or overflowed ones.
  - done=1; illegal and overflow as computed. Go to IDLE.
- Latency: handshake at cycle N -> rf_we/done at N+3. Throughput: one instruction per 4 cycles.
- instr_ready is low in READ/EXEC/WB. instr_valid during those states is ignored; fetch must hold it.
- Illegal codes go through the same path with uniform latency and no write.
- pc wraps modulo 2^32.
- alu_a, alu_b and alu_op hold their last values outside EXEC.

Decomposition:
- Package alu_pkg:
  - instruction ID constants (ID_ADD=1 .. ID_SRL=12)
  - FSM state enum (IDLE, READ, EXEC, WB)
  - ir field bit positions
  - PC_STEP default
- Sub-module alu_seq_decode (combinational), with outputs:
  - dest select (rd/rt)
  - operand-B source (reg/simm/zimm/shamt)
  - legal flag
  - overflow class (none/add/sub)
  - operand-A-from-rt flag

Test Plan:
- addi, rs=1 (value 5), rt=2, imm=16'hFFFF -> rf_we at N+3, rf_waddr=2, rf_wdata=4, pc=4, done=1.
- add, rs=0x7FFFFFFF, rt=1 -> overflow=1, rf_we=0, pc advances by 4; the same operands with addu -> write 0x80000000, overflow=0.
- Illegal and zero-destination cases:
  - instr_ID=13 -> illegal=1 with done, no rf_we, pc+=4.
  - add with rd=0 -> done=1, no rf_we.
- ori rs=3 (0x0000F000), imm=16'h8001 -> rf_wdata=0x0000F001 (zero-extended); sll rt=4 (0x1), shamt=31 -> 0x80000000.
- Back-to-back: instr_valid held high for two instructions -> second accepted exactly at N+4, instr_ready=0 for cycles N+1..N+3.
- reset driven low during EXEC -> immediate IDLE, pc=PC_RESET, no rf_we; the next instruction after release executes normally.
